// File: rtl/lcd_frame_seq_pkg.sv
// Shared LCD sequencer definitions: FSM encodings, HD44780 DDRAM constants, RS values.
package lcd_pkg;

   typedef enum logic [2:0] {
      S_INIT       = 3'd0,
      S_INIT_WAIT  = 3'd1,
      S_ADDR       = 3'd2,
      S_ADDR_WAIT  = 3'd3,
      S_FETCH      = 3'd4,
      S_WRITE      = 3'd5,
      S_WRITE_WAIT = 3'd6,
      S_IDLE       = 3'd7
   } state_t;

   localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
   localparam logic [7:0] LINE_BASE_0   = 8'h00;
   localparam logic [7:0] LINE_BASE_1   = 8'h40;
   localparam logic [7:0] LINE_BASE_2   = 8'h14;
   localparam logic [7:0] LINE_BASE_3   = 8'h54;

   localparam logic RS_CMD  = 1'b0;
   localparam logic RS_DATA = 1'b1;

   // Lines 2/3 continue lines 0/1 in DDRAM, hence the non-monotonic bases.
   function automatic logic [7:0] line_base(input logic [1:0] line);
      case (line)
         2'd0:    return LINE_BASE_0;
         2'd1:    return LINE_BASE_1;
         2'd2:    return LINE_BASE_2;
         default: return LINE_BASE_3;
      endcase
   endfunction

endpackage

// File: rtl/lcd_frame_seq_if.sv
// Handshake bundle between the frame sequencer and the init FSM, write engine and char buffer.
interface lcd_frame_seq_if #(parameter int ADDR_W = 5);

   logic              init_start;
   logic              init_done;
   logic              cmd_start;
   logic              cmd_rs;
   logic [7:0]        cmd_byte;
   logic              cmd_done;
   logic [ADDR_W-1:0] char_addr;
   logic [7:0]        char_data;

   modport master (
      output init_start, cmd_start, cmd_rs, cmd_byte, char_addr,
      input  init_done, cmd_done, char_data
   );

   modport slave (
      input  init_start, cmd_start, cmd_rs, cmd_byte, char_addr,
      output init_done, cmd_done, char_data
   );

endinterface

// File: rtl/lcd_frame_seq_pos_counter.sv
// Character index / line position tracker with line-end and frame-end flags.
module lcd_pos_counter #(
   parameter int NUM_CHARS      = 32,
   parameter int CHARS_PER_LINE = 16,
   parameter int ADDR_W         = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              inc,
   output logic [ADDR_W-1:0] index,
   output logic [1:0]        line,
   output logic              line_end,
   output logic              frame_end
);

   localparam logic [ADDR_W-1:0] LAST_CHAR = ADDR_W'(NUM_CHARS - 1);
   localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(CHARS_PER_LINE - 1);

   // A column counter avoids a modulo on the index to find line ends.
   logic [ADDR_W-1:0] col;

   assign line_end  = (col == LAST_COL);
   assign frame_end = (index == LAST_CHAR);

   // Advance position; clear has priority so a restart never half-increments.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         index <= '0;
         col   <= '0;
         line  <= 2'd0;
      end else if (inc) begin
         index <= index + ADDR_W'(1);
         if (line_end) begin
            col  <= '0;
            line <= line + 2'd1;
         end else begin
            col <= col + ADDR_W'(1);
         end
      end
   end

endmodule

// File: rtl/lcd_frame_seq.sv
// LCD frame sequencer: init handshake, then frames of characters with DDRAM
// set-address commands at each line start; continuous or single-shot.
//
//  state        | meaning
//  S_INIT       | pulse init_start
//  S_INIT_WAIT  | wait for init FSM to finish
//  S_ADDR       | issue set-DDRAM-address for current line
//  S_ADDR_WAIT  | wait for address command to complete
//  S_FETCH      | char_addr presented, buffer read in progress
//  S_WRITE      | latch char_data and issue it as data
//  S_WRITE_WAIT | wait for data byte, then pick next step
//  S_IDLE       | single-shot frame finished, waiting for refresh_req
module lcd_frame_seq
   import lcd_pkg::*;
#(
   parameter int NUM_CHARS      = 32,
   parameter int CHARS_PER_LINE = 16,
   parameter int ADDR_W         = 5,
   parameter bit CONTINUOUS     = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   lcd_frame_seq_if.master   lcd,
   input  logic              refresh_req,
   output logic              busy,
   output logic              frame_done
);

   state_t            state, state_nxt;
   logic              init_start_q, init_start_nxt;
   logic              cmd_start_q, cmd_start_nxt;
   logic              cmd_rs_q, cmd_rs_nxt;
   logic [7:0]        cmd_byte_q, cmd_byte_nxt;
   logic              frame_done_q, frame_done_nxt;
   logic              busy_q, busy_nxt;
   logic              pending_q, pending_nxt;
   logic              cnt_clr, cnt_inc;
   logic              restart;
   logic              refresh_window;
   logic [ADDR_W-1:0] index;
   logic [1:0]        line;
   logic              line_end, frame_end;

   lcd_pos_counter #(
      .NUM_CHARS      (NUM_CHARS),
      .CHARS_PER_LINE (CHARS_PER_LINE),
      .ADDR_W         (ADDR_W)
   ) u_pos (
      .clk       (clk),
      .reset     (reset),
      .clr       (cnt_clr),
      .inc       (cnt_inc),
      .index     (index),
      .line      (line),
      .line_end  (line_end),
      .frame_end (frame_end)
   );

   // Refresh requests are only remembered once the panel is initialised and streaming.
   assign refresh_window = state inside {S_ADDR, S_ADDR_WAIT, S_FETCH, S_WRITE, S_WRITE_WAIT};
   assign restart        = pending_q | refresh_req;

   // Next-state and next-output decode; outputs are registered so pulses are glitch-free.
   always_comb begin
      state_nxt      = state;
      init_start_nxt = 1'b0;
      cmd_start_nxt  = 1'b0;
      cmd_rs_nxt     = cmd_rs_q;
      cmd_byte_nxt   = cmd_byte_q;
      frame_done_nxt = 1'b0;
      pending_nxt    = pending_q | (refresh_req & refresh_window);
      cnt_clr        = 1'b0;
      cnt_inc        = 1'b0;
      case (state)
         S_INIT: begin
            init_start_nxt = 1'b1;
            state_nxt      = S_INIT_WAIT;
         end
         S_INIT_WAIT: begin
            if (lcd.init_done) state_nxt = S_ADDR;
         end
         S_ADDR: begin
            cmd_start_nxt = 1'b1;
            cmd_rs_nxt    = RS_CMD;
            cmd_byte_nxt  = CMD_SET_DDRAM | line_base(line);
            state_nxt     = S_ADDR_WAIT;
         end
         S_ADDR_WAIT: begin
            if (lcd.cmd_done) state_nxt = S_FETCH;
         end
         S_FETCH: begin
            state_nxt = S_WRITE;
         end
         S_WRITE: begin
            cmd_start_nxt = 1'b1;
            cmd_rs_nxt    = RS_DATA;
            cmd_byte_nxt  = lcd.char_data;
            state_nxt     = S_WRITE_WAIT;
         end
         S_WRITE_WAIT: begin
            if (lcd.cmd_done) begin
               if (frame_end) begin
                  frame_done_nxt = 1'b1;
                  cnt_clr        = 1'b1;
                  pending_nxt    = 1'b0;
                  state_nxt      = (CONTINUOUS || restart) ? S_ADDR : S_IDLE;
               end else if (restart) begin
                  cnt_clr     = 1'b1;
                  pending_nxt = 1'b0;
                  state_nxt   = S_ADDR;
               end else if (line_end) begin
                  cnt_inc   = 1'b1;
                  state_nxt = S_ADDR;
               end else begin
                  cnt_inc   = 1'b1;
                  state_nxt = S_FETCH;
               end
            end
         end
         S_IDLE: begin
            if (refresh_req) begin
               cnt_clr   = 1'b1;
               state_nxt = S_ADDR;
            end
         end
         default: state_nxt = S_INIT;
      endcase
      busy_nxt = (state_nxt != S_IDLE);
   end

   // State and output registers; reset aborts any transfer in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_INIT;
         init_start_q <= 1'b0;
         cmd_start_q  <= 1'b0;
         cmd_rs_q     <= 1'b0;
         cmd_byte_q   <= 8'h00;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
         pending_q    <= 1'b0;
      end else begin
         state        <= state_nxt;
         init_start_q <= init_start_nxt;
         cmd_start_q  <= cmd_start_nxt;
         cmd_rs_q     <= cmd_rs_nxt;
         cmd_byte_q   <= cmd_byte_nxt;
         frame_done_q <= frame_done_nxt;
         busy_q       <= busy_nxt;
         pending_q    <= pending_nxt;
      end
   end

   assign lcd.init_start = init_start_q;
   assign lcd.cmd_start  = cmd_start_q;
   assign lcd.cmd_rs     = cmd_rs_q;
   assign lcd.cmd_byte   = cmd_byte_q;
   assign lcd.char_addr  = index;
   assign busy           = busy_q;
   assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_lcd_frame_seq.sv
// Bench for lcd_frame_seq: three instances (default, single-shot, 80x20) with
// write-engine responders, character ROMs and command loggers.
module tb_lcd_frame_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
   logic ref0 = 1'b0, ref1 = 1'b0, ref2 = 1'b0;
   logic busy0, busy1, busy2;
   logic fd0, fd1, fd2;

   lcd_frame_seq_if #(.ADDR_W(5)) if0 ();
   lcd_frame_seq_if #(.ADDR_W(5)) if1 ();
   lcd_frame_seq_if #(.ADDR_W(7)) if2 ();

   lcd_frame_seq #(.NUM_CHARS(32), .CHARS_PER_LINE(16), .ADDR_W(5), .CONTINUOUS(1'b1)) u0 (
      .clk(clk), .reset(rst0), .lcd(if0), .refresh_req(ref0), .busy(busy0), .frame_done(fd0));
   lcd_frame_seq #(.NUM_CHARS(32), .CHARS_PER_LINE(16), .ADDR_W(5), .CONTINUOUS(1'b0)) u1 (
      .clk(clk), .reset(rst1), .lcd(if1), .refresh_req(ref1), .busy(busy1), .frame_done(fd1));
   lcd_frame_seq #(.NUM_CHARS(80), .CHARS_PER_LINE(20), .ADDR_W(7), .CONTINUOUS(1'b1)) u2 (
      .clk(clk), .reset(rst2), .lcd(if2), .refresh_req(ref2), .busy(busy2), .frame_done(fd2));

   // Character buffers: synchronous read, contents 0x41 + address.
   always @(posedge clk) if0.char_data <= 8'h41 + {3'b000, if0.char_addr};
   always @(posedge clk) if1.char_data <= 8'h41 + {3'b000, if1.char_addr};
   always @(posedge clk) if2.char_data <= 8'h41 + {1'b0, if2.char_addr};

   // Write-engine models: cmd_done 3 cycles after cmd_start; not reset with the DUT.
   int rc0 = 0, rc1 = 0, rc2 = 0;
   always @(posedge clk) begin
      if0.cmd_done <= 1'b0;
      if (if0.cmd_start === 1'b1) rc0 <= 2;
      else if (rc0 > 0) begin rc0 <= rc0 - 1; if (rc0 == 1) if0.cmd_done <= 1'b1; end
   end
   always @(posedge clk) begin
      if1.cmd_done <= 1'b0;
      if (if1.cmd_start === 1'b1) rc1 <= 2;
      else if (rc1 > 0) begin rc1 <= rc1 - 1; if (rc1 == 1) if1.cmd_done <= 1'b1; end
   end
   always @(posedge clk) begin
      if2.cmd_done <= 1'b0;
      if (if2.cmd_start === 1'b1) rc2 <= 2;
      else if (rc2 > 0) begin rc2 <= rc2 - 1; if (rc2 == 1) if2.cmd_done <= 1'b1; end
   end

   // Command logs {rs, byte}, pulse counters and overlapping-command counters.
   logic [8:0] q0[$], q1[$], q2[$];
   int fdc0 = 0, fdc1 = 0, fdc2 = 0;
   int isc0 = 0;
   int viol0 = 0, viol1 = 0, viol2 = 0;
   bit out0 = 0, out1 = 0, out2 = 0;

   always @(negedge clk) begin
      if (if0.cmd_start === 1'b1) begin
         if (out0) viol0 <= viol0 + 1;
         out0 <= 1'b1;
         q0.push_back({if0.cmd_rs, if0.cmd_byte});
      end else if (if0.cmd_done === 1'b1) out0 <= 1'b0;
      if (fd0 === 1'b1) fdc0 <= fdc0 + 1;
      if (if0.init_start === 1'b1) isc0 <= isc0 + 1;
   end
   always @(negedge clk) begin
      if (if1.cmd_start === 1'b1) begin
         if (out1) viol1 <= viol1 + 1;
         out1 <= 1'b1;
         q1.push_back({if1.cmd_rs, if1.cmd_byte});
      end else if (if1.cmd_done === 1'b1) out1 <= 1'b0;
      if (fd1 === 1'b1) fdc1 <= fdc1 + 1;
   end
   always @(negedge clk) begin
      if (if2.cmd_start === 1'b1) begin
         if (out2) viol2 <= viol2 + 1;
         out2 <= 1'b1;
         q2.push_back({if2.cmd_rs, if2.cmd_byte});
      end else if (if2.cmd_done === 1'b1) out2 <= 1'b0;
      if (fd2 === 1'b1) fdc2 <= fdc2 + 1;
   end

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic int qsize(input int sel);
      case (sel)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   function automatic logic [8:0] qget(input int sel, input int idx);
      if (idx >= qsize(sel)) return 9'h1FF;
      case (sel)
         0:       return q0[idx];
         1:       return q1[idx];
         default: return q2[idx];
      endcase
   endfunction

   task automatic wait_size(input int sel, input int n, input int budget, input string name);
      int c = 0;
      while (qsize(sel) < n && c < budget) begin
         @(posedge clk);
         c++;
      end
      if (qsize(sel) < n) begin
         checks++;
         failures++;
         $display("FAIL %s timeout: cmds=%0d required=%0d", name, qsize(sel), n);
      end
   endtask

   typedef struct {
      int sel;
      int idx;
      int exp;
   } vec_t;
   vec_t vecs[$];

   task automatic run_vecs(input int sel);
      foreach (vecs[i])
         if (vecs[i].sel == sel)
            check($sformatf("cmd_u%0d_%0d", sel, vecs[i].idx), 32'(qget(sel, vecs[i].idx)), vecs[i].exp);
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "global timeout");
   end

   initial begin
      int c;
      int isc_base;
      // Default frame: 0x80, 'A'..'P', 0xC0, 'Q'..'`', then 0x80 again.
      vecs.push_back('{0, 0, 'h080});
      for (int i = 0; i < 16; i++) vecs.push_back('{0, 1 + i, 'h141 + i});
      vecs.push_back('{0, 17, 'h0C0});
      for (int i = 0; i < 16; i++) vecs.push_back('{0, 18 + i, 'h151 + i});
      vecs.push_back('{0, 34, 'h080});
      // 80x20: each line start preceded by its set-address byte.
      vecs.push_back('{2, 0,  'h080}); vecs.push_back('{2, 1,  'h141});
      vecs.push_back('{2, 21, 'h0C0}); vecs.push_back('{2, 22, 'h141 + 20});
      vecs.push_back('{2, 42, 'h094}); vecs.push_back('{2, 43, 'h141 + 40});
      vecs.push_back('{2, 63, 'h0D4}); vecs.push_back('{2, 64, 'h141 + 60});
      vecs.push_back('{2, 83, 'h141 + 79});

      if0.init_done = 1'b0;
      if1.init_done = 1'b1;
      if2.init_done = 1'b1;

      // Reset state and init handshake
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_pulses", 32'({if0.init_start, if0.cmd_start, if0.cmd_rs, busy0, fd0}), 0);
      check("reset_cmd_byte", 32'(if0.cmd_byte), 0);
      check("reset_char_addr", 32'(if0.char_addr), 0);
      rst0 = 1'b0;
      @(negedge clk);
      check("init_start_cycle1", 32'(if0.init_start), 1);
      check("busy_after_reset", 32'(busy0), 1);
      @(negedge clk);
      check("init_start_cycle2", 32'(if0.init_start), 0);
      repeat (50) @(posedge clk);
      check("init_pulse_count", isc0, 1);
      check("no_cmd_before_init", qsize(0), 0);
      #1 if0.init_done = 1'b1;

      // Full frame, continuous mode
      wait_size(0, 35, 800, "frame_u0");
      run_vecs(0);
      check("frame_done_u0", fdc0, 1);

      // Refresh while char 10 of the second frame is in flight
      wait_size(0, 46, 400, "char10_u0");
      check("char10_inflight", 32'(qget(0, 45)), 'h14B);
      #1 ref0 = 1'b1;
      @(posedge clk);
      #1 ref0 = 1'b0;
      wait_size(0, 48, 100, "restart_u0");
      check("restart_addr", 32'(qget(0, 46)), 'h080);
      check("restart_char0", 32'(qget(0, 47)), 'h141);
      check("restart_no_frame_done", fdc0, 1);

      // Reset during S_WRITE_WAIT; the in-flight done arrives during init
      wait_size(0, 49, 100, "char1_u0");
      #1 rst0 = 1'b1;
      if0.init_done = 1'b0;
      isc_base = isc0;
      @(posedge clk);
      @(negedge clk);
      check("midreset_pulses", 32'({if0.init_start, if0.cmd_start, if0.cmd_rs, busy0, fd0}), 0);
      check("midreset_byte_addr", 32'({if0.cmd_byte, 3'b000, if0.char_addr}), 0);
      rst0 = 1'b0;
      repeat (10) @(posedge clk);
      check("midreset_init_pulses", isc0 - isc_base, 1);
      check("midreset_no_cmd", qsize(0), 49);
      #1 if0.init_done = 1'b1;
      wait_size(0, 51, 100, "after_reset_u0");
      check("after_reset_addr", 32'(qget(0, 49)), 'h080);
      check("after_reset_char0", 32'(qget(0, 50)), 'h141);
      check("overlap_u0", viol0, 0);

      // Single-shot mode
      #1 rst1 = 1'b0;
      wait_size(1, 34, 800, "frame_u1");
      c = 0;
      while (fdc1 < 1 && c < 20) begin @(posedge clk); c++; end
      repeat (100) @(posedge clk);
      check("oneshot_first", 32'(qget(1, 0)), 'h080);
      check("oneshot_line1", 32'(qget(1, 17)), 'h0C0);
      check("oneshot_last", 32'(qget(1, 33)), 'h160);
      check("oneshot_busy", 32'(busy1), 0);
      check("oneshot_quiet", qsize(1), 34);
      check("oneshot_frame_done", fdc1, 1);
      #1 ref1 = 1'b1;
      @(posedge clk);
      #1 ref1 = 1'b0;
      wait_size(1, 36, 100, "refresh_u1");
      check("oneshot_refresh_addr", 32'(qget(1, 34)), 'h080);
      check("oneshot_refresh_char0", 32'(qget(1, 35)), 'h141);
      check("oneshot_busy_again", 32'(busy1), 1);

      // Refresh coinciding with the last character's cmd_done
      wait_size(1, 68, 800, "lastchar_u1");
      check("oneshot_last2", 32'(qget(1, 67)), 'h160);
      for (c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         if (if1.cmd_done === 1'b1) break;
      end
      if (c == 10) begin
         checks++;
         failures++;
         $display("FAIL lastdone_u1 timeout: cmd_done not seen");
      end
      ref1 = 1'b1;
      @(posedge clk);
      #1 ref1 = 1'b0;
      wait_size(1, 70, 100, "coincide_u1");
      check("coincide_addr", 32'(qget(1, 68)), 'h080);
      check("coincide_char0", 32'(qget(1, 69)), 'h141);
      check("coincide_frame_done", fdc1, 2);
      check("overlap_u1", viol1, 0);

      // 80 chars, 20 per line
      #1 rst2 = 1'b0;
      wait_size(2, 84, 2000, "frame_u2");
      repeat (10) @(posedge clk);
      run_vecs(2);
      check("frame_done_u2", fdc2, 1);
      check("overlap_u2", viol2, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
